mux_n_pipe: RTL and testbench

//  Parametrised N-way, W-bit select mux with a registered, back-pressured output.

---
 rtl/mux_n_pipe.sv | 132 +++++++++++++
 tb/tb_mux_n_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way, W-bit select mux with a registered, back-pressured output.
// A main register (M) drives the outputs and a skid register (S) absorbs one
// extra beat, so in_ready can come straight from a flop.
// Optional feature macro: MUX_PIPE_ERR_CNT_EN adds a saturating 16-bit count
// of accepted beats whose select was out of range (err_count port).
//
// Handshake: a beat transfers on a rising edge where valid and ready are both
// high. A producer holds valid and its payload steady until that happens.
// in_ready never depends combinationally on out_ready.
module mux_n_pipe #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] DEFAULT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_PIPE_ERR_CNT_EN
  ,
  output logic [15:0]             err_count
`endif
);

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  logic             m_valid, m_err;
  logic [WIDTH-1:0] m_data;
  logic             s_valid, s_err;
  logic [WIDTH-1:0] s_data;

  logic             m_valid_nxt, m_err_nxt;
  logic [WIDTH-1:0] m_data_nxt;
  logic             s_valid_nxt, s_err_nxt;
  logic [WIDTH-1:0] s_data_nxt;

  logic             accept;
  logic             m_free;

  assign accept = in_valid & in_ready;
  // M can take a new beat when it is empty or its beat leaves this edge.
  assign m_free = ~m_valid | out_ready;

  assign out_valid   = m_valid;
  assign out_data    = m_data;
  assign out_sel_err = m_err;

  // Select mux; an unmatched select falls through to the constant with err set.
  always_comb begin
    mux_data = DEFAULT_VAL;
    mux_err  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        mux_data = in_data[i*WIDTH +: WIDTH];
        mux_err  = 1'b0;
      end
    end
  end

  // Next-state for the M/S pair: S drains into M first so order is kept.
  always_comb begin
    m_valid_nxt = m_valid;
    m_data_nxt  = m_data;
    m_err_nxt   = m_err;
    s_valid_nxt = s_valid;
    s_data_nxt  = s_data;
    s_err_nxt   = s_err;
    if (m_free) begin
      if (s_valid) begin
        m_valid_nxt = 1'b1;
        m_data_nxt  = s_data;
        m_err_nxt   = s_err;
        s_valid_nxt = accept;
        if (accept) begin
          s_data_nxt = mux_data;
          s_err_nxt  = mux_err;
        end
      end else begin
        m_valid_nxt = accept;
        if (accept) begin
          m_data_nxt = mux_data;
          m_err_nxt  = mux_err;
        end
      end
    end else if (accept) begin
      s_valid_nxt = 1'b1;
      s_data_nxt  = mux_data;
      s_err_nxt   = mux_err;
    end
  end

  // Storage registers; in_ready is registered as the inverse of next S valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_err    <= 1'b0;
      s_valid  <= 1'b0;
      s_data   <= '0;
      s_err    <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      m_valid  <= m_valid_nxt;
      m_data   <= m_data_nxt;
      m_err    <= m_err_nxt;
      s_valid  <= s_valid_nxt;
      s_data   <= s_data_nxt;
      s_err    <= s_err_nxt;
      in_ready <= ~s_valid_nxt;
    end
  end

`ifdef MUX_PIPE_ERR_CNT_EN
  // Saturating count of accepted out-of-range beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (accept && mux_err && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_n_pipe.sv
// Bench for mux_n_pipe: two instances (4-way and 3-way with a 0x1F default)
// share one stimulus stream and are checked against a queue model.
module tb_mux_n_pipe;

  localparam int NA = 4;
  localparam int NB = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   sel = '0;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  logic        a_in_ready, a_out_sel_err, a_out_valid;
  logic [31:0] a_out_data;
  logic        b_in_ready, b_out_sel_err, b_out_valid;
  logic [31:0] b_out_data;
`ifdef MUX_PIPE_ERR_CNT_EN
  logic [15:0] a_err_count, b_err_count;
`endif

  mux_n_pipe #(.WIDTH(32), .NUM_IN(NA), .SEL_W(2), .DEFAULT_VAL(32'h0)) dut_a (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_sel_err(a_out_sel_err),
    .out_valid(a_out_valid), .out_ready(out_ready)
`ifdef MUX_PIPE_ERR_CNT_EN
    , .err_count(a_err_count)
`endif
  );

  mux_n_pipe #(.WIDTH(32), .NUM_IN(NB), .SEL_W(2), .DEFAULT_VAL(32'h1F)) dut_b (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data[95:0]), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_sel_err(b_out_sel_err),
    .out_valid(b_out_valid), .out_ready(out_ready)
`ifdef MUX_PIPE_ERR_CNT_EN
    , .err_count(b_err_count)
`endif
  );

  // clock
  always #5 clk = ~clk;

  // scoreboard: expected beats in flight, {err, data}
  logic [32:0] qa[$];
  logic [32:0] qb[$];
  logic [32:0] dummy;
  bit          rdy_block = 1'b1;
  int          cnt_a = 0;
  int          cnt_b = 0;
  int          passed = 0;
  int          total = 0;

  typedef struct {
    logic [1:0]  s;
    logic [31:0] exp_a;
    logic        err_a;
    logic [31:0] exp_b;
    logic        err_b;
  } vec_t;
  vec_t vecs[4];

  logic [127:0] dfix;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    else passed++;
  endtask

  function automatic logic [32:0] model(input int n, input logic [31:0] dflt,
                                        input logic [1:0] s, input logic [127:0] d);
    if (int'(s) < n) return {1'b0, 32'(d >> (32 * int'(s)))};
    return {1'b1, dflt};
  endfunction

  task automatic check_model();
    chk("a_out_valid", 64'(a_out_valid), 64'(qa.size() > 0));
    chk("b_out_valid", 64'(b_out_valid), 64'(qb.size() > 0));
    if (qa.size() > 0) chk("a_beat", 64'({a_out_sel_err, a_out_data}), 64'(qa[0]));
    if (qb.size() > 0) chk("b_beat", 64'({b_out_sel_err, b_out_data}), 64'(qb[0]));
    chk("a_in_ready", 64'(a_in_ready), 64'(!rdy_block && qa.size() < 2));
    chk("b_in_ready", 64'(b_in_ready), 64'(!rdy_block && qb.size() < 2));
`ifdef MUX_PIPE_ERR_CNT_EN
    chk("a_err_count", 64'(a_err_count), 64'(cnt_a));
    chk("b_err_count", 64'(b_err_count), 64'(cnt_b));
`endif
  endtask

  task automatic clear_model();
    qa.delete();
    qb.delete();
    rdy_block = 1'b1;
    cnt_a = 0;
    cnt_b = 0;
  endtask

  // driver: one clock of stimulus, returns right at the rising edge
  task automatic cycle(input logic v, input logic [1:0] s, input logic [127:0] d, input logic r);
    logic acc_a, acc_b, emt_a, emt_b;
    @(negedge clk);
    in_valid = v; sel = s; in_data = d; out_ready = r;
    #1;
    check_model();
    acc_a = v & a_in_ready;
    acc_b = v & b_in_ready;
    emt_a = a_out_valid & r;
    emt_b = b_out_valid & r;
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      if (emt_a) dummy = qa.pop_front();
      if (emt_b) dummy = qb.pop_front();
      if (acc_a) begin
        qa.push_back(model(NA, 32'h0, s, d));
        if (int'(s) >= NA && cnt_a < 65535) cnt_a++;
      end
      if (acc_b) begin
        qb.push_back(model(NB, 32'h1F, s, d));
        if (int'(s) >= NB && cnt_b < 65535) cnt_b++;
      end
      rdy_block = 1'b0;
    end
  endtask

  initial begin
    dfix = {32'd44, 32'd33, 32'd22, 32'd11};
    vecs[0] = '{2'd0, 32'd11, 1'b0, 32'd11, 1'b0};
    vecs[1] = '{2'd1, 32'd22, 1'b0, 32'd22, 1'b0};
    vecs[2] = '{2'd2, 32'd33, 1'b0, 32'd33, 1'b0};
    vecs[3] = '{2'd3, 32'd44, 1'b0, 32'h1F, 1'b1};

    // reset state
    cycle(1'b0, 2'd0, dfix, 1'b1);
    cycle(1'b0, 2'd0, dfix, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_data", 64'(a_out_data), 64'd0);
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    cycle(1'b0, 2'd0, dfix, 1'b1);
    #1 chk("rel_in_ready", 64'(a_in_ready), 64'd1);

    // select table, streamed back to back
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, vecs[i].s, dfix, 1'b1);
      #1;
      chk("tab_a_valid", 64'(a_out_valid), 64'd1);
      chk("tab_a_data", 64'(a_out_data), 64'(vecs[i].exp_a));
      chk("tab_a_err", 64'(a_out_sel_err), 64'(vecs[i].err_a));
      chk("tab_b_data", 64'(b_out_data), 64'(vecs[i].exp_b));
      chk("tab_b_err", 64'(b_out_sel_err), 64'(vecs[i].err_b));
      chk("tab_in_ready", 64'(a_in_ready), 64'd1);
    end
    cycle(1'b0, 2'd0, dfix, 1'b1);
`ifdef MUX_PIPE_ERR_CNT_EN
    #1 chk("tab_b_err_count", 64'(b_err_count), 64'd1);
`endif

    // back-pressure: three pushes, two land, output held
    cycle(1'b1, 2'd0, dfix, 1'b0);
    cycle(1'b1, 2'd1, dfix, 1'b0);
    cycle(1'b1, 2'd2, dfix, 1'b0);
    #1;
    chk("bp_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp_held_data", 64'(a_out_data), 64'd11);
    cycle(1'b0, 2'd0, dfix, 1'b1);
    #1;
    chk("bp_second", 64'(a_out_data), 64'd22);
    chk("bp_ready_back", 64'(a_in_ready), 64'd1);
    cycle(1'b0, 2'd0, dfix, 1'b1);
    #1 chk("bp_drained", 64'(a_out_valid), 64'd0);

    // async reset with two beats held
    cycle(1'b1, 2'd0, dfix, 1'b0);
    cycle(1'b1, 2'd3, dfix, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(a_out_valid), 64'd0);
    chk("mid_rst_ready", 64'(a_in_ready), 64'd0);
    chk("mid_rst_data", 64'(a_out_data), 64'd0);
    chk("mid_rst_b_err", 64'(b_out_sel_err), 64'd0);
`ifdef MUX_PIPE_ERR_CNT_EN
    chk("mid_rst_cnt", 64'(b_err_count), 64'd0);
`endif
    clear_model();
    cycle(1'b1, 2'd1, dfix, 1'b1);
    #2 rst = 1'b0;
    cycle(1'b0, 2'd0, dfix, 1'b1);
    #1 chk("mid_rel_ready", 64'(a_in_ready), 64'd1);

    // randomized traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            {$urandom, $urandom, $urandom, $urandom},
            ($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'd0, dfix, 1'b1);

`ifdef MUX_PIPE_ERR_CNT_EN
    // counter saturation
    for (int i = 0; i < 65537; i++) cycle(1'b1, 2'd3, dfix, 1'b1);
    #1 chk("sat_count", 64'(b_err_count), 64'hFFFF);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'd3, dfix, 1'b1);
    #1 chk("sat_stays", 64'(b_err_count), 64'hFFFF);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
